// File: rtl/apb_master_mc.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// apb_master_mc
//
// Multi-slave APB4 master. It accepts one command at a time on a valid/ready
// stream, runs the matching APB transfer on the slave picked by an address
// field, and returns exactly one response pulse per accepted command.
//
// Ports
//   PCLK, PRESETn        clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; ready only while idle
//   cmd_write            1 = write, 0 = read
//   cmd_addr/wdata/strb  byte address, write data, byte enables
//   rsp_valid            one-cycle response pulse (no backpressure)
//   rsp_rdata            read data, zero for writes and for any error
//   rsp_err/rsp_timeout  error flag, and whether the error was a timeout
//   PADDR/PWDATA/PSTRB/PWRITE  registered APB request fields
//   PSELx/PENABLE        one-hot slave select and enable phase
//   PRDATA/PREADY/PSLVERR      per-slave return buses, muxed internally
// ---------------------------------------------------------------------------
module apb_master_mc #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NSLV    = 4,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [DATA_W-1:0]      cmd_wdata,
    input  logic [DATA_W/8-1:0]    cmd_strb,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   rsp_timeout,
    output logic [ADDR_W-1:0]      PADDR,
    output logic [DATA_W-1:0]      PWDATA,
    output logic [DATA_W/8-1:0]    PSTRB,
    output logic                   PWRITE,
    output logic [NSLV-1:0]        PSELx,
    output logic                   PENABLE,
    input  logic [NSLV*DATA_W-1:0] PRDATA,
    input  logic [NSLV-1:0]        PREADY,
    input  logic [NSLV-1:0]        PSLVERR
);

    localparam int STRB_W = DATA_W / 8;
    localparam int SEL_W  = (NSLV > 1) ? $clog2(NSLV) : 0;
    // Index register keeps at least one bit so a single-slave build still
    // has a legal (constant zero) index.
    localparam int IDX_W  = (SEL_W > 0) ? SEL_W : 1;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN  = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        SETUP  = 4'b0010,
        ACCESS = 4'b0100,
        RESP   = 4'b1000
    } state_t;

    state_t state_reg, state_next;

    logic [IDX_W-1:0]  cmd_idx;
    logic              decode_ok;
    logic              accept;

    logic [IDX_W-1:0]  idx_reg;
    logic [ADDR_W-1:0] paddr_reg;
    logic [DATA_W-1:0] pwdata_reg;
    logic [STRB_W-1:0] pstrb_reg;
    logic              pwrite_reg;
    logic [CNT_W-1:0]  wait_cnt_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              err_reg;
    logic              timeout_reg;

    logic [NSLV-1:0]   sel_onehot;
    logic              sel_ready;
    logic              sel_err;
    logic [DATA_W-1:0] sel_rdata;
    logic              timeout_hit;

    // ---------------------------------------------------------------------
    // Slave index decode from the command address
    // ---------------------------------------------------------------------
    generate
        if (SEL_W > 0) begin : g_idx
            assign cmd_idx = cmd_addr[SEL_LSB +: SEL_W];
        end else begin : g_idx_single
            assign cmd_idx = '0;
        end
    endgenerate

    // Non-power-of-two slave counts leave index codes with no slave behind
    // them; those become decode errors without touching the bus.
    assign decode_ok = ({1'b0, cmd_idx} < (IDX_W + 1)'(NSLV));
    assign accept    = (state_reg == IDLE) && cmd_valid;

    // One-hot of the registered index; also the select mask for the return
    // buses, so only the addressed slave's PREADY/PSLVERR/PRDATA matter.
    genvar gi;
    generate
        for (gi = 0; gi < NSLV; gi++) begin : g_sel
            assign sel_onehot[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign sel_ready = |(PREADY  & sel_onehot);
    assign sel_err   = |(PSLVERR & sel_onehot);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_onehot[i]) begin
                sel_rdata = PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    // The counter equals the number of ACCESS cycles already spent, so the
    // abort happens in the (TIMEOUT+1)-th ACCESS cycle unless PREADY wins.
    assign timeout_hit = TO_EN && (wait_cnt_reg == TIMEOUT_C);

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state and control outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        PSELx      = '0;
        PENABLE    = 1'b0;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = decode_ok ? SETUP : RESP;
                end
            end
            SETUP: begin
                PSELx      = sel_onehot;
                state_next = ACCESS;
            end
            ACCESS: begin
                PSELx   = sel_onehot;
                PENABLE = 1'b1;
                if (sel_ready || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath: request fields, wait counter, response capture
    // ---------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            idx_reg      <= '0;
            paddr_reg    <= '0;
            pwdata_reg   <= '0;
            pstrb_reg    <= '0;
            pwrite_reg   <= 1'b0;
            wait_cnt_reg <= '0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            if (accept) begin
                idx_reg    <= cmd_idx;
                paddr_reg  <= cmd_addr;
                pwrite_reg <= cmd_write;
                // Reads never drive data or strobes onto the bus.
                pwdata_reg <= cmd_write ? cmd_wdata : '0;
                pstrb_reg  <= cmd_write ? cmd_strb  : '0;
                if (!decode_ok) begin
                    err_reg     <= 1'b1;
                    timeout_reg <= 1'b0;
                    rdata_reg   <= '0;
                end
            end

            if (accept && decode_ok) begin
                wait_cnt_reg <= '0;
            end else if ((state_reg == ACCESS) && !sel_ready && !timeout_hit &&
                         (wait_cnt_reg != '1)) begin
                // Saturating: with the timeout disabled it simply parks.
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end

            if (state_reg == ACCESS) begin
                if (sel_ready) begin
                    err_reg     <= sel_err;
                    timeout_reg <= 1'b0;
                    rdata_reg   <= (!pwrite_reg && !sel_err) ? sel_rdata : '0;
                end else if (timeout_hit) begin
                    err_reg     <= 1'b1;
                    timeout_reg <= 1'b1;
                    rdata_reg   <= '0;
                end
            end
        end
    end

    assign PADDR  = paddr_reg;
    assign PWDATA = pwdata_reg;
    assign PSTRB  = pstrb_reg;
    assign PWRITE = pwrite_reg;

    // Response fields are only meaningful while rsp_valid is high.
    assign rsp_rdata   = rsp_valid ? rdata_reg : '0;
    assign rsp_err     = rsp_valid & err_reg;
    assign rsp_timeout = rsp_valid & timeout_reg;

endmodule

// File: tb/tb_apb_master_mc.sv
`timescale 1ns/1ps
// Testbench for apb_master_mc: a 4-slave instance (TIMEOUT = 4) and a
// 3-slave instance for decode errors, driven by a shared behavioural slave.
module tb_apb_master_mc;

    logic        PCLK;
    logic        PRESETn;
    logic        use3;
    logic        cmd_valid;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;

    // slave behaviour for the current vector
    logic [7:0]  cur_waits;
    logic        cur_serr;
    logic [31:0] cur_prdata;
    logic [3:0]  cur_noise;

    logic [127:0] prdata_bus;
    logic [3:0]   pready_bus;
    logic [3:0]   pslverr_bus;

    // 4-slave instance outputs
    logic        cmd_ready4, rsp_valid4, rsp_err4, rsp_to4, pwrite4, penable4;
    logic [31:0] rsp_rdata4, paddr4, pwdata4;
    logic [3:0]  pstrb4, psel4;
    // 3-slave instance outputs
    logic        cmd_ready3, rsp_valid3, rsp_err3, rsp_to3, pwrite3, penable3;
    logic [31:0] rsp_rdata3, paddr3, pwdata3;
    logic [3:0]  pstrb3;
    logic [2:0]  psel3;

    apb_master_mc #(.ADDR_W(32), .DATA_W(32), .NSLV(4), .SEL_LSB(12), .TIMEOUT(4)) u_dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid & ~use3), .cmd_ready(cmd_ready4),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid4), .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4), .rsp_timeout(rsp_to4),
        .PADDR(paddr4), .PWDATA(pwdata4), .PSTRB(pstrb4), .PWRITE(pwrite4),
        .PSELx(psel4), .PENABLE(penable4),
        .PRDATA(prdata_bus), .PREADY(pready_bus), .PSLVERR(pslverr_bus)
    );

    apb_master_mc #(.ADDR_W(32), .DATA_W(32), .NSLV(3), .SEL_LSB(12), .TIMEOUT(4)) u_dut3 (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid & use3), .cmd_ready(cmd_ready3),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3), .rsp_timeout(rsp_to3),
        .PADDR(paddr3), .PWDATA(pwdata3), .PSTRB(pstrb3), .PWRITE(pwrite3),
        .PSELx(psel3), .PENABLE(penable3),
        .PRDATA(prdata_bus[95:0]), .PREADY(pready_bus[2:0]), .PSLVERR(pslverr_bus[2:0])
    );

    // monitor view of whichever instance is active
    logic [3:0]  m_psel, m_pstrb;
    logic        m_penable, m_rsp_valid, m_rsp_err, m_rsp_to, m_pwrite, m_cmd_ready;
    logic [31:0] m_rdata, m_paddr, m_pwdata;
    assign m_psel      = use3 ? {1'b0, psel3} : psel4;
    assign m_penable   = use3 ? penable3   : penable4;
    assign m_rsp_valid = use3 ? rsp_valid3 : rsp_valid4;
    assign m_rsp_err   = use3 ? rsp_err3   : rsp_err4;
    assign m_rsp_to    = use3 ? rsp_to3    : rsp_to4;
    assign m_rdata     = use3 ? rsp_rdata3 : rsp_rdata4;
    assign m_paddr     = use3 ? paddr3     : paddr4;
    assign m_pwdata    = use3 ? pwdata3    : pwdata4;
    assign m_pstrb     = use3 ? pstrb3     : pstrb4;
    assign m_pwrite    = use3 ? pwrite3    : pwrite4;
    assign m_cmd_ready = use3 ? cmd_ready3 : cmd_ready4;

    // Behavioural slaves: the selected one answers after cur_waits ACCESS
    // cycles; unselected ones drive cur_noise on PREADY and inverted data.
    logic [7:0] acc_cnt;
    logic       hit;
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                     acc_cnt <= 8'd0;
        else if (m_penable && |m_psel)    acc_cnt <= acc_cnt + 8'd1;
        else                              acc_cnt <= 8'd0;
    end
    assign hit = m_penable && (acc_cnt == cur_waits);

    always_comb begin
        pready_bus  = '0;
        pslverr_bus = '0;
        prdata_bus  = '0;
        for (int i = 0; i < 4; i++) begin
            pready_bus[i]          = m_psel[i] ? hit : cur_noise[i];
            pslverr_bus[i]         = m_psel[i] & hit & cur_serr;
            prdata_bus[i*32 +: 32] = m_psel[i] ? cur_prdata : ~cur_prdata;
        end
    end

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        use3;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [7:0]  waits;
        logic        serr;
        logic [31:0] prdata;
        logic [3:0]  noise;
        logic [3:0]  e_psel;
        int          e_lat;
        int          e_pen;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_to;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input int n, input vec_t v);
        int          k;
        int          pen;
        logic [3:0]  psel_or;
        logic        seen;
        logic [3:0]  psel_r, pstrb_r;
        logic [31:0] rdata_r, paddr_r, pwdata_r;
        logic        err_r, to_r, pwrite_r;
        psel_r = '0; pstrb_r = '0; rdata_r = '0; paddr_r = '0; pwdata_r = '0;
        err_r = 1'b0; to_r = 1'b0; pwrite_r = 1'b0;

        @(negedge PCLK);
        use3       = v.use3;
        cur_waits  = v.waits;
        cur_serr   = v.serr;
        cur_prdata = v.prdata;
        cur_noise  = v.noise;
        cmd_write  = v.write;
        cmd_addr   = v.addr;
        cmd_wdata  = v.wdata;
        cmd_strb   = v.strb;
        cmd_valid  = 1'b1;
        check($sformatf("v%0d_cmd_ready", n), m_cmd_ready, 1);
        @(negedge PCLK);           // accept edge has passed; cycle N+1
        cmd_valid = 1'b0;
        k = 1; pen = 0; psel_or = '0; seen = 1'b0;
        while (k <= 40) begin
            pen += int'(m_penable);
            psel_or |= m_psel;
            if (m_rsp_valid) begin
                seen = 1'b1;
                psel_r = m_psel; rdata_r = m_rdata; err_r = m_rsp_err; to_r = m_rsp_to;
                paddr_r = m_paddr; pwdata_r = m_pwdata; pstrb_r = m_pstrb; pwrite_r = m_pwrite;
                break;
            end
            @(negedge PCLK);
            k++;
        end
        check($sformatf("v%0d_rsp_seen", n), seen, 1);
        check($sformatf("v%0d_latency", n), k, v.e_lat);
        check($sformatf("v%0d_penable_cycles", n), pen, v.e_pen);
        check($sformatf("v%0d_psel", n), psel_or, v.e_psel);
        check($sformatf("v%0d_psel_in_rsp", n), psel_r, 0);
        check($sformatf("v%0d_rdata", n), rdata_r, v.e_rdata);
        check($sformatf("v%0d_err", n), err_r, v.e_err);
        check($sformatf("v%0d_timeout", n), to_r, v.e_to);
        check($sformatf("v%0d_paddr", n), paddr_r, v.addr);
        check($sformatf("v%0d_pwrite", n), pwrite_r, v.write);
        check($sformatf("v%0d_pstrb", n), pstrb_r, v.write ? v.strb : 4'h0);
        check($sformatf("v%0d_pwdata", n), pwdata_r, v.write ? v.wdata : 32'h0);
        @(negedge PCLK);
        check($sformatf("v%0d_rsp_one_cycle", n), m_rsp_valid, 0);
        check($sformatf("v%0d_ready_after", n), m_cmd_ready, 1);
        $display("[TB] vec %0d %s addr=%08h lat=%0d pen=%0d psel=%b err=%0b to=%0b rdata=%08h",
                 n, v.write ? "WR" : "RD", v.addr, k, pen, psel_or, err_r, to_r, rdata_r);
    endtask

    initial begin
        int  k;
        bit  rsp_seen;

        //          use3  wr    addr          wdata         strb  waits   serr  prdata        noise    e_psel   lat pen e_rdata       err   to
        vecs[0] = '{1'b0, 1'b1, 32'h0000_1010, 32'hA5A5_5A5A, 4'hF, 8'd0,   1'b0, 32'h0,        4'b0000, 4'b0010, 3, 1, 32'h0,        1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_3004, 32'h1234_5678, 4'hF, 8'd3,   1'b0, 32'hDEAD_BEEF, 4'b0000, 4'b1000, 6, 4, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_2000, 32'h0,        4'hF, 8'd0,   1'b1, 32'h1111_2222, 4'b0000, 4'b0100, 3, 1, 32'h0,        1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,        4'hF, 8'd255, 1'b0, 32'h5555_5555, 4'b0000, 4'b0001, 7, 5, 32'h0,        1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0000_BEEF, 4'h3, 8'd1,   1'b0, 32'h0,        4'b1110, 4'b0001, 4, 2, 32'h0,        1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_1FFC, 32'h0,        4'h0, 8'd4,   1'b0, 32'hCAFE_F00D, 4'b0000, 4'b0010, 7, 5, 32'hCAFE_F00D, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_3000, 32'h8765_4321, 4'hC, 8'd2,   1'b1, 32'hFFFF_FFFF, 4'b0000, 4'b1000, 5, 3, 32'h0,        1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,        4'hF, 8'd0,   1'b0, 32'h0,        4'b0000, 4'b0000, 1, 0, 32'h0,        1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 32'h0000_2010, 32'h0,        4'hF, 8'd0,   1'b0, 32'h0102_0304, 4'b0011, 4'b0100, 3, 1, 32'h0102_0304, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 1'b1, 32'h0000_F000, 32'h0BAD_F00D, 4'h5, 8'd0,   1'b0, 32'h0,        4'b0000, 4'b0000, 1, 0, 32'h0,        1'b1, 1'b0};

        use3 = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
        cur_waits = 8'd0; cur_serr = 1'b0; cur_prdata = '0; cur_noise = '0;
        PRESETn = 1'b0;

        // reset state
        #12;
        check("rst_cmd_ready", cmd_ready4, 1);
        check("rst_rsp_valid", rsp_valid4, 0);
        check("rst_psel", psel4, 0);
        check("rst_penable", penable4, 0);
        check("rst_paddr", paddr4, 0);
        check("rst_pstrb", pstrb4, 0);
        check("rst_pwdata", pwdata4, 0);
        check("rst_pwrite", pwrite4, 0);
        check("rst_rsp_err", rsp_err4, 0);
        check("rst3_cmd_ready", cmd_ready3, 1);
        @(negedge PCLK);
        PRESETn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_vec(i, vecs[i]);
        end

        // reset in the middle of an ACCESS phase
        @(negedge PCLK);
        use3 = 1'b0; cur_waits = 8'd255; cur_serr = 1'b0; cur_noise = '0;
        cmd_write = 1'b0; cmd_addr = 32'h0000_0040; cmd_valid = 1'b1;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        k = 0;
        while (!penable4 && k < 20) begin
            @(negedge PCLK);
            k++;
        end
        check("mrst_reach_access", penable4, 1);
        @(negedge PCLK);
        #2 PRESETn = 1'b0;
        #1;
        check("mrst_psel", psel4, 0);
        check("mrst_penable", penable4, 0);
        check("mrst_rsp_valid", rsp_valid4, 0);
        check("mrst_cmd_ready", cmd_ready4, 1);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        rsp_seen = 1'b0;
        repeat (12) begin
            @(negedge PCLK);
            if (rsp_valid4) rsp_seen = 1'b1;
        end
        check("mrst_no_rsp", rsp_seen, 0);
        $display("[TB] mid-transfer reset sequence done");

        // normal operation after the reset
        run_vec(10, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
